// File: rtl/seq_control_unit_pkg.sv
// instruction_set: z8 opcodes, sequencer states, control types and decode helpers
package instruction_set;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXECUTE, MEM_WAIT, WRITEBACK, HALTED
    } CU_STATE_T;

    // D-forms take the src field as an immediate, R-forms as a register
    typedef enum logic [7:0] {
        NOP  = 8'h00,
        ADD  = 8'h01, ADR  = 8'h02,
        SBD  = 8'h03, SBR  = 8'h04,
        AND  = 8'h05, ANR  = 8'h06,
        ORD  = 8'h07, ORR  = 8'h08,
        XOD  = 8'h09, XOR  = 8'h0A,
        LDD  = 8'h0B, LDR  = 8'h0C, LDM  = 8'h0D,
        STD  = 8'h0E, STR  = 8'h0F,
        JPD  = 8'h10, JPR  = 8'h11,
        JZD  = 8'h12, JZR  = 8'h13,
        JNZD = 8'h14, JNZR = 8'h15,
        JND  = 8'h16, JNR  = 8'h17,
        HALT = 8'h1F
    } OPCODES_T;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } FLAGS_T;

    typedef enum logic [1:0] {MEM_NOP, MEM_READ, MEM_WRITE} MEM_OPS_T;

    typedef enum logic [2:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_PASS
    } ALU_OPS_T;

    typedef enum logic {REG, VAL} DATA_SOURCE_T;

    // Per-opcode control bundle: which fields feed the register/memory addresses and what EXECUTE loads
    typedef struct packed {
        logic         use_a;
        logic         use_b;
        logic         mem_src;
        logic         mem_dest;
        ALU_OPS_T     alu;
        DATA_SOURCE_T b_sel;
        MEM_OPS_T     mem;
    } decode_t;

    function automatic logic is_known(logic [7:0] code);
        return code inside {NOP, ADD, ADR, SBD, SBR, AND, ANR, ORD, ORR, XOD, XOR,
                            LDD, LDR, LDM, STD, STR, JPD, JPR, JZD, JZR,
                            JNZD, JNZR, JND, JNR, HALT};
    endfunction

    function automatic logic is_rf_write(OPCODES_T op);
        return op inside {ADD, ADR, LDM, LDR, LDD, SBR, SBD, ANR, AND, ORR, ORD, XOR, XOD};
    endfunction

    // A = dest for ALU ops and register-indirect jumps; B = src for register-sourced ops.
    // Loads address memory with src, stores with dest.
    function automatic decode_t decode(OPCODES_T op);
        decode_t c;
        c = '0;
        c.use_a    = op inside {ADD, ADR, SBD, SBR, AND, ANR, ORD, ORR, XOD, XOR, JPR, JZR, JNZR, JNR};
        c.use_b    = op inside {ADR, SBR, ANR, ORR, XOR, LDR, STR};
        c.mem_src  = op == LDM;
        c.mem_dest = op inside {STR, STD};
        c.alu      = op inside {ADD, ADR} ? ALU_ADD :
                     op inside {SBD, SBR} ? ALU_SUB :
                     op inside {AND, ANR} ? ALU_AND :
                     op inside {ORD, ORR} ? ALU_OR  :
                     op inside {XOD, XOR} ? ALU_XOR :
                     op inside {LDD, LDR, STD, STR} ? ALU_PASS : ALU_NOP;
        c.b_sel    = op inside {ADD, SBD, AND, ORD, XOD, LDD, STD, JPD, JZD, JNZD, JND} ? VAL : REG;
        c.mem      = op == LDM ? MEM_READ : c.mem_dest ? MEM_WRITE : MEM_NOP;
        return c;
    endfunction

endpackage

// File: rtl/seq_control_unit_branch.sv
// cu_branch_unit: jump condition evaluation and next-PC selection
module cu_branch_unit
    import instruction_set::*;
#(
    parameter int ADDR_W = 16
) (
    input  OPCODES_T          op,
    input  logic              zero,
    input  logic              negative,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] dest,
    input  logic [ADDR_W-1:0] rf_data,
    output logic [ADDR_W-1:0] next_pc,
    output logic              taken
);

    // Taken jumps go to the register (xR) or the dest field (xD); everything else steps the PC
    always_comb begin
        taken   = op inside {JPD, JPR} ||
                  (op inside {JZD, JZR} && zero) ||
                  (op inside {JNZD, JNZR} && !zero) ||
                  (op inside {JND, JNR} && negative);
        next_pc = !taken ? pc + ADDR_W'(1) :
                  op inside {JPR, JZR, JNZR, JNR} ? rf_data : dest;
    end

endmodule

// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle fetch/decode/execute/memory/writeback sequencer for the z8 core
module seq_control_unit
    import instruction_set::*;
#(
    parameter  int DATA_W     = 16,
    parameter  int ADDR_W     = 16,
    parameter  int REG_ADDR_W = 2,
    parameter  int OPCODE_W   = 8,
    localparam int INSTR_W    = OPCODE_W + 2 * DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INSTR_W-1:0]    instruction,
    input  logic                  instr_valid,
    output logic                  fetch_req,
    input  logic [ADDR_W-1:0]     pc,
    output logic [ADDR_W-1:0]     next_pc,
    output logic                  pc_write,
    input  FLAGS_T                flags_in,
    input  logic                  update_flags,
    input  logic [DATA_W-1:0]     rf_read_data_a,
    output logic                  rf_write_enable,
    output logic [REG_ADDR_W-1:0] rf_write_addr,
    output logic [REG_ADDR_W-1:0] rf_read_addr_a,
    output logic [REG_ADDR_W-1:0] rf_read_addr_b,
    output logic [ADDR_W-1:0]     mem_rw_addr,
    output MEM_OPS_T              mem_op,
    input  logic                  mem_ready,
    output ALU_OPS_T              alu_op,
    output DATA_SOURCE_T          alu_a_src_sel,
    output DATA_SOURCE_T          alu_b_src_sel,
    output CU_STATE_T             current_state,
    output logic                  halted,
    input  logic                  resume,
    output logic                  illegal_op
);

    localparam int OPX_W = (OPCODE_W > 8) ? OPCODE_W : 8;

    CU_STATE_T             state_q, state_d;
    logic [INSTR_W-1:0]    ir_q, ir_d;
    FLAGS_T                flags_q, flags_d;
    logic [REG_ADDR_W-1:0] rf_read_addr_a_q, rf_read_addr_a_d;
    logic [REG_ADDR_W-1:0] rf_read_addr_b_q, rf_read_addr_b_d;
    logic [ADDR_W-1:0]     mem_rw_addr_q, mem_rw_addr_d;
    MEM_OPS_T              mem_op_q, mem_op_d;
    ALU_OPS_T              alu_op_q, alu_op_d;
    DATA_SOURCE_T          alu_a_src_sel_q, alu_a_src_sel_d;
    DATA_SOURCE_T          alu_b_src_sel_q, alu_b_src_sel_d;

    logic [OPX_W-1:0]  op_ext;
    logic              op_ok;
    OPCODES_T          op;
    decode_t           dec;
    logic [DATA_W-1:0] dest, src;
    logic [ADDR_W-1:0] br_next_pc;
    logic              br_taken;
    logic              unused_bits;

    // Opcodes wider than the enum are legal only when the extra high bits are zero;
    // anything unrecognised is carried through the pipeline as a NOP
    assign op_ext = OPX_W'(ir_q[INSTR_W-1 -: OPCODE_W]);
    assign op_ok  = is_known(op_ext[7:0]) && ((op_ext >> 8) == '0);
    assign op     = op_ok ? OPCODES_T'(op_ext[7:0]) : NOP;
    assign dec    = decode(op);
    assign dest   = ir_q[2*DATA_W-1 -: DATA_W];
    assign src    = ir_q[DATA_W-1:0];

    cu_branch_unit #(.ADDR_W(ADDR_W)) u_branch (
        .op       (op),
        .zero     (flags_q.zero),
        .negative (flags_q.negative),
        .pc       (pc),
        .dest     (dest[ADDR_W-1:0]),
        .rf_data  (rf_read_data_a[ADDR_W-1:0]),
        .next_pc  (br_next_pc),
        .taken    (br_taken)
    );

    assign unused_bits     = ^{flags_q.carry, flags_q.overflow, br_taken};
    assign rf_write_addr   = dest[REG_ADDR_W-1:0];
    assign rf_read_addr_a  = rf_read_addr_a_q;
    assign rf_read_addr_b  = rf_read_addr_b_q;
    assign mem_rw_addr     = mem_rw_addr_q;
    assign mem_op          = mem_op_q;
    assign alu_op          = alu_op_q;
    assign alu_a_src_sel   = alu_a_src_sel_q;
    assign alu_b_src_sel   = alu_b_src_sel_q;
    assign current_state   = state_q;
    assign halted          = state_q == HALTED;

    // Sequencer transitions, registered-control loads and the combinational strobes
    always_comb begin
        state_d          = state_q;
        ir_d             = ir_q;
        flags_d          = update_flags ? flags_in : flags_q;
        rf_read_addr_a_d = rf_read_addr_a_q;
        rf_read_addr_b_d = rf_read_addr_b_q;
        mem_rw_addr_d    = mem_rw_addr_q;
        mem_op_d         = mem_op_q;
        alu_op_d         = alu_op_q;
        alu_a_src_sel_d  = alu_a_src_sel_q;
        alu_b_src_sel_d  = alu_b_src_sel_q;
        fetch_req        = 1'b0;
        pc_write         = 1'b0;
        next_pc          = pc;
        rf_write_enable  = 1'b0;
        illegal_op       = 1'b0;
        case (state_q)
            FETCH: begin
                fetch_req = 1'b1;
                ir_d      = instr_valid ? instruction : ir_q;
                state_d   = instr_valid ? DECODE : FETCH;
            end
            DECODE: begin
                rf_read_addr_a_d = dec.use_a ? dest[REG_ADDR_W-1:0] : '0;
                rf_read_addr_b_d = dec.use_b ? src[REG_ADDR_W-1:0] : '0;
                mem_rw_addr_d    = dec.mem_src ? src[ADDR_W-1:0] : dec.mem_dest ? dest[ADDR_W-1:0] : '0;
                illegal_op       = !op_ok;
                state_d          = op == HALT ? HALTED : EXECUTE;
            end
            EXECUTE: begin
                alu_op_d        = dec.alu;
                alu_a_src_sel_d = REG;
                alu_b_src_sel_d = dec.b_sel;
                mem_op_d        = dec.mem;
                state_d         = dec.mem != MEM_NOP ? MEM_WAIT : WRITEBACK;
            end
            MEM_WAIT: begin
                mem_op_d = mem_ready ? MEM_NOP : mem_op_q;
                state_d  = mem_ready ? WRITEBACK : MEM_WAIT;
            end
            WRITEBACK: begin
                rf_write_enable  = is_rf_write(op);
                pc_write         = 1'b1;
                next_pc          = br_next_pc;
                rf_read_addr_a_d = '0;
                rf_read_addr_b_d = '0;
                mem_rw_addr_d    = '0;
                mem_op_d         = MEM_NOP;
                alu_op_d         = ALU_NOP;
                alu_a_src_sel_d  = REG;
                alu_b_src_sel_d  = REG;
                state_d          = FETCH;
            end
            HALTED: begin
                pc_write = resume;
                next_pc  = resume ? pc + ADDR_W'(1) : pc;
                state_d  = resume ? FETCH : HALTED;
            end
            default: state_d = FETCH;
        endcase
    end

    // State and registered controls; reset aborts any memory transaction at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= FETCH;
            ir_q             <= '0;
            flags_q          <= '0;
            rf_read_addr_a_q <= '0;
            rf_read_addr_b_q <= '0;
            mem_rw_addr_q    <= '0;
            mem_op_q         <= MEM_NOP;
            alu_op_q         <= ALU_NOP;
            alu_a_src_sel_q  <= REG;
            alu_b_src_sel_q  <= REG;
        end else begin
            state_q          <= state_d;
            ir_q             <= ir_d;
            flags_q          <= flags_d;
            rf_read_addr_a_q <= rf_read_addr_a_d;
            rf_read_addr_b_q <= rf_read_addr_b_d;
            mem_rw_addr_q    <= mem_rw_addr_d;
            mem_op_q         <= mem_op_d;
            alu_op_q         <= alu_op_d;
            alu_a_src_sel_q  <= alu_a_src_sel_d;
            alu_b_src_sel_q  <= alu_b_src_sel_d;
        end
    end

endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: directed and random instruction checks against an instruction-level model
module tb_seq_control_unit;
    import instruction_set::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [39:0]  instruction = '0;
    logic         instr_valid = 1'b0;
    logic         fetch_req;
    logic [15:0]  pc = '0;
    logic [15:0]  next_pc;
    logic         pc_write;
    FLAGS_T       flags_in = '0;
    logic         update_flags = 1'b0;
    logic [15:0]  rf_read_data_a = '0;
    logic         rf_write_enable;
    logic [1:0]   rf_write_addr, rf_read_addr_a, rf_read_addr_b;
    logic [15:0]  mem_rw_addr;
    MEM_OPS_T     mem_op;
    logic         mem_ready = 1'b0;
    ALU_OPS_T     alu_op;
    DATA_SOURCE_T alu_a_src_sel, alu_b_src_sel;
    CU_STATE_T    current_state;
    logic         halted;
    logic         resume = 1'b0;
    logic         illegal_op;

    int   errors = 0;
    int   checks = 0;
    logic mz = 1'b0, mn = 1'b0;

    logic [7:0] ops [24] = '{NOP, ADD, ADR, SBD, SBR, AND, ANR, ORD, ORR, XOD, XOR, LDD,
                             LDR, LDM, STD, STR, JPD, JPR, JZD, JZR, JNZD, JNZR, JND, JNR};

    typedef struct {
        logic [1:0]   ra, rb;
        logic [15:0]  maddr, npc;
        ALU_OPS_T     alu;
        DATA_SOURCE_T bsel;
        MEM_OPS_T     mem;
        logic         we, ill, halt;
    } exp_t;

    always #5 clk = ~clk;

    seq_control_unit dut (
        .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .fetch_req(fetch_req), .pc(pc), .next_pc(next_pc), .pc_write(pc_write),
        .flags_in(flags_in), .update_flags(update_flags), .rf_read_data_a(rf_read_data_a),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
        .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
        .mem_rw_addr(mem_rw_addr), .mem_op(mem_op), .mem_ready(mem_ready), .alu_op(alu_op),
        .alu_a_src_sel(alu_a_src_sel), .alu_b_src_sel(alu_b_src_sel),
        .current_state(current_state), .halted(halted), .resume(resume), .illegal_op(illegal_op)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // What one instruction should do, stated from the instruction set's rules
    function automatic exp_t model(input logic [7:0] opc, input logic [15:0] d, s, p, rfa,
                                   input logic z, n);
        exp_t     e;
        logic     known, alu_r, alu_d, jr, jd, taken;
        OPCODES_T op;
        known  = opc inside {NOP, ADD, ADR, SBD, SBR, AND, ANR, ORD, ORR, XOD, XOR, LDD, LDR, LDM,
                             STD, STR, JPD, JPR, JZD, JZR, JNZD, JNZR, JND, JNR, HALT};
        op     = known ? OPCODES_T'(opc) : NOP;
        e.ill  = !known;
        e.halt = op == HALT;
        alu_r  = op inside {ADR, SBR, ANR, ORR, XOR};
        alu_d  = op inside {ADD, SBD, AND, ORD, XOD};
        jr     = op inside {JPR, JZR, JNZR, JNR};
        jd     = op inside {JPD, JZD, JNZD, JND};
        e.ra    = (alu_r || alu_d || jr) ? d[1:0] : 2'd0;
        e.rb    = (alu_r || op inside {LDR, STR}) ? s[1:0] : 2'd0;
        e.maddr = op == LDM ? s : op inside {STR, STD} ? d : 16'd0;
        case (op)
            ADD, ADR: e.alu = ALU_ADD;
            SBD, SBR: e.alu = ALU_SUB;
            AND, ANR: e.alu = ALU_AND;
            ORD, ORR: e.alu = ALU_OR;
            XOD, XOR: e.alu = ALU_XOR;
            LDD, LDR, STD, STR: e.alu = ALU_PASS;
            default: e.alu = ALU_NOP;
        endcase
        e.bsel = (alu_d || jd || op inside {LDD, STD}) ? VAL : REG;
        e.mem  = op == LDM ? MEM_READ : op inside {STR, STD} ? MEM_WRITE : MEM_NOP;
        e.we   = alu_r || alu_d || op inside {LDM, LDR, LDD};
        taken  = op inside {JPD, JPR} || (op inside {JZD, JZR} && z) ||
                 (op inside {JNZD, JNZR} && !z) || (op inside {JND, JNR} && n);
        e.npc  = taken ? (jr ? rfa : d) : p + 16'd1;
        return e;
    endfunction

    task automatic set_flags(input logic z, input logic n);
        flags_in     = '{zero: z, negative: n, carry: 1'b1, overflow: 1'b0};
        update_flags = 1'b1;
        #1;
        chk("fetch_hold", current_state, FETCH);
        tick();
        update_flags = 1'b0;
        mz = z;
        mn = n;
    endtask

    // Walks one instruction through the sequencer; zw/nw are flags written during WRITEBACK
    task automatic run(input logic [7:0] opc, input logic [15:0] d, s, p, rfa,
                       input int waits, input logic zw, nw);
        exp_t e;
        e = model(opc, d, s, p, rfa, mz, mn);
        instruction    = {opc, d, s};
        instr_valid    = 1'b1;
        pc             = p;
        rf_read_data_a = rfa;
        #1;
        chk("f_state", current_state, FETCH);
        chk("f_req", fetch_req, 1'b1);
        tick();
        instr_valid = 1'b0;
        instruction = '1;
        #1;
        chk("d_state", current_state, DECODE);
        chk("d_illegal", illegal_op, e.ill);
        tick();
        #1;
        if (e.halt) begin
            chk("h_state", current_state, HALTED);
            chk("h_halted", halted, 1'b1);
            return;
        end
        chk("e_state", current_state, EXECUTE);
        chk("e_illegal", illegal_op, 1'b0);
        chk("e_ra", rf_read_addr_a, e.ra);
        chk("e_rb", rf_read_addr_b, e.rb);
        chk("e_maddr", mem_rw_addr, e.maddr);
        chk("e_alu", alu_op, ALU_NOP);
        tick();
        if (e.mem != MEM_NOP) begin
            for (int i = 0; i <= waits; i++) begin
                mem_ready = (i == waits);
                #1;
                chk("m_state", current_state, MEM_WAIT);
                chk("m_op", mem_op, e.mem);
                chk("m_addr", mem_rw_addr, e.maddr);
                chk("m_alu", alu_op, e.alu);
                tick();
            end
            mem_ready = 1'b0;
        end
        flags_in     = '{zero: zw, negative: nw, carry: 1'b0, overflow: 1'b1};
        update_flags = 1'b1;
        #1;
        chk("w_state", current_state, WRITEBACK);
        chk("w_we", rf_write_enable, e.we);
        chk("w_waddr", rf_write_addr, d[1:0]);
        chk("w_pcw", pc_write, 1'b1);
        chk("w_npc", next_pc, e.npc);
        chk("w_alu", alu_op, e.alu);
        chk("w_asel", alu_a_src_sel, REG);
        chk("w_bsel", alu_b_src_sel, e.bsel);
        chk("w_mem", mem_op, MEM_NOP);
        tick();
        update_flags = 1'b0;
        mz = zw;
        mn = nw;
        #1;
        chk("x_state", current_state, FETCH);
        chk("x_maddr", mem_rw_addr, 16'd0);
        chk("x_alu", alu_op, ALU_NOP);
        chk("x_ra", rf_read_addr_a, 2'd0);
        chk("x_bsel", alu_b_src_sel, REG);
        chk("x_pcw", pc_write, 1'b0);
        chk("x_npc", next_pc, p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("r_state", current_state, FETCH);
        chk("r_mem", mem_op, MEM_NOP);
        chk("r_alu", alu_op, ALU_NOP);
        chk("r_maddr", mem_rw_addr, 16'd0);
        chk("r_ra", rf_read_addr_a, 2'd0);
        chk("r_rb", rf_read_addr_b, 2'd0);
        chk("r_bsel", alu_b_src_sel, REG);
        chk("r_halted", halted, 1'b0);
        chk("r_pcw", pc_write, 1'b0);
        reset = 1'b0;
        tick();
        run(ADD, 16'h0001, 16'h0005, 16'h0010, 16'h0000, 0, 1'b0, 1'b0);
        run(LDM, 16'h0002, 16'h0040, 16'h0011, 16'h0000, 3, 1'b0, 1'b0);
        set_flags(1'b1, 1'b0);
        run(JZD, 16'h0100, 16'h0000, 16'h0020, 16'h0000, 0, 1'b0, 1'b0);
        run(JZD, 16'h0100, 16'h0000, 16'h0021, 16'h0000, 0, 1'b1, 1'b0);
        run(JPR, 16'h0003, 16'h0000, 16'h0030, 16'h1234, 0, 1'b0, 1'b1);
        run(JND, 16'h0200, 16'h0000, 16'h0031, 16'h0000, 0, 1'b0, 1'b0);
        run(JNZR, 16'h0001, 16'h0000, 16'h0032, 16'h4321, 0, 1'b0, 1'b0);
        run(NOP, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 0, 1'b0, 1'b0);
        run(8'hFF, 16'h0003, 16'h0007, 16'h0040, 16'h0000, 0, 1'b0, 1'b0);
        run(STR, 16'h0080, 16'h0002, 16'h0041, 16'h0000, 0, 1'b0, 1'b0);
        run(HALT, 16'h0000, 16'h0000, 16'h0050, 16'h0000, 0, 1'b0, 1'b0);
        repeat (10) begin
            tick();
            chk("halt_hold", current_state, HALTED);
            chk("halt_pcw", pc_write, 1'b0);
            chk("halt_npc", next_pc, 16'h0050);
            chk("halt_mem", mem_op, MEM_NOP);
        end
        resume = 1'b1;
        #1;
        chk("res_pcw", pc_write, 1'b1);
        chk("res_npc", next_pc, 16'h0051);
        tick();
        resume = 1'b0;
        chk("res_state", current_state, FETCH);
        chk("res_halted", halted, 1'b0);
        instruction = {STR, 16'h0033, 16'h0001};
        instr_valid = 1'b1;
        pc          = 16'h0060;
        #1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("rm_state", current_state, MEM_WAIT);
        chk("rm_op", mem_op, MEM_WRITE);
        chk("rm_addr", mem_rw_addr, 16'h0033);
        #2;
        reset = 1'b1;
        #1;
        chk("ra_state", current_state, FETCH);
        chk("ra_mem", mem_op, MEM_NOP);
        chk("ra_addr", mem_rw_addr, 16'h0000);
        #1;
        reset = 1'b0;
        mz    = 1'b0;
        mn    = 1'b0;
        tick();
        run(ADR, 16'h0002, 16'h0003, 16'h0070, 16'h0000, 0, 1'b0, 1'b0);
        for (int k = 0; k < 120; k++) begin
            logic [7:0] opc;
            opc = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : ops[$urandom_range(0, 23)];
            if (opc == HALT) opc = 8'hFF;
            if ($urandom_range(0, 3) == 0) set_flags(1'($urandom), 1'($urandom));
            run(opc, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
